// File: rtl/tcam_match_encoder.sv
// Drains a captured CAM hit vector as a stream of entry indices, one per handshake.
// Define TCAM_ENC_HIGH_FIRST_EN to emit the highest index first instead of the lowest.
module tcam_match_encoder #(
  parameter int MEMORY_SIZE = 20,
  localparam int ADDR_WIDTH = $clog2(MEMORY_SIZE),
  localparam int CNT_WIDTH  = $clog2(MEMORY_SIZE + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [MEMORY_SIZE-1:0] matched,
  input  logic                   load,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_WIDTH-1:0]  out_addr,
  output logic                   out_last,
  output logic                   busy,
  output logic                   hit,
  output logic [CNT_WIDTH-1:0]   match_count,
  output logic                   done
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                 state;
  state_t                 state_next;
  logic [MEMORY_SIZE-1:0] pending;
  logic [MEMORY_SIZE-1:0] sel_onehot;
  logic [ADDR_WIDTH-1:0]  sel_idx;
  logic [ADDR_WIDTH-1:0]  addr_hold;
  logic [CNT_WIDTH-1:0]   pop;
  logic                   single;
  logic                   handshake;

  // Priority select: the last match found in loop order wins.
  always_comb begin
    sel_idx    = '0;
    sel_onehot = '0;
`ifdef TCAM_ENC_HIGH_FIRST_EN
    for (int i = 0; i < MEMORY_SIZE; i++) begin
`else
    for (int i = MEMORY_SIZE - 1; i >= 0; i--) begin
`endif
      if (pending[i]) begin
        sel_idx       = ADDR_WIDTH'(i);
        sel_onehot    = '0;
        sel_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < MEMORY_SIZE; i++) begin
      pop = pop + CNT_WIDTH'(matched[i]);
    end
  end

  assign single = (pending != '0) &&
                  ((pending & (pending - MEMORY_SIZE'(1))) == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_addr   = addr_hold;
    handshake  = 1'b0;
    case (state)
      IDLE: begin
        if (load && (matched != '0)) begin
          state_next = EMIT;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        out_last  = single;
        out_addr  = sel_idx;
        handshake = out_ready;
        if (out_ready && single) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = out_valid;

  // In IDLE, out_addr keeps showing the most recently emitted index.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending     <= '0;
      hit         <= 1'b0;
      match_count <= '0;
      done        <= 1'b0;
      addr_hold   <= '0;
    end else begin
      done <= 1'b0;
      if ((state == IDLE) && load) begin
        pending     <= matched;
        hit         <= |matched;
        match_count <= pop;
        done        <= (matched == '0);
      end else if (handshake) begin
        pending   <= pending & ~sel_onehot;
        addr_hold <= sel_idx;
        done      <= single;
      end
    end
  end

endmodule

// File: tb/tb_tcam_match_encoder.sv
// Self-checking bench for tcam_match_encoder: directed vector table, reset-mid-drain
// sequence and randomized captures checked against an index-order queue model.
module tb_tcam_match_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] matched;
  logic        load;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_addr;
  logic        out_last;
  logic        busy;
  logic        hit;
  logic [4:0]  match_count;
  logic        done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [19:0] matched;
    int          stall;
    int          exp_count;
    bit          exp_hit;
    int          exp_first;
  } vec_t;

  vec_t vecs[$];

  tcam_match_encoder #(.MEMORY_SIZE(20)) dut (
    .clk        (clk),
    .reset      (reset),
    .matched    (matched),
    .load       (load),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_last   (out_last),
    .busy       (busy),
    .hit        (hit),
    .match_count(match_count),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Capture m, then drain it; returns in the done cycle so a following call loads back-to-back.
  task automatic applyStimulus(input logic [19:0] m, input int stall, input bit rnd,
                               input int exp_first, input int exp_count, input bit exp_hit);
    int exp_q[$];
    int cyc;
    bit hs;
    for (int i = 0; i < 20; i++) begin
      if (m[i]) begin
`ifdef TCAM_ENC_HIGH_FIRST_EN
        exp_q.push_front(i);
`else
        exp_q.push_back(i);
`endif
      end
    end
    load      = 1'b1;
    matched   = m;
    out_ready = 1'b0;
    #1;
    tick();
    load    = 1'b0;
    matched = '0;
    cyc     = 0;
    while (exp_q.size() > 0 && cyc < 200) begin
      if (rnd) begin
        out_ready = 1'($urandom_range(0, 1));
        load      = ($urandom_range(0, 3) == 0);
        matched   = 20'($urandom);
      end else begin
        out_ready = (cyc >= stall);
        load      = (cyc < stall);
        matched   = 20'hFFFFF;
      end
      #1;
      if (cyc == 0 && exp_first >= 0) checkOutput("first_addr", int'(out_addr), exp_first);
      checkOutput("out_valid", int'(out_valid), 1);
      checkOutput("out_addr", int'(out_addr), exp_q[0]);
      checkOutput("out_last", int'(out_last), (exp_q.size() == 1) ? 1 : 0);
      checkOutput("busy", int'(busy), 1);
      checkOutput("hit_emit", int'(hit), int'(exp_hit));
      checkOutput("count_emit", int'(match_count), exp_count);
      checkOutput("done_emit", int'(done), 0);
      hs = out_ready;
      tick();
      if (hs) void'(exp_q.pop_front());
      cyc++;
    end
    checkOutput("drain_timeout", exp_q.size(), 0);
    load      = 1'b0;
    out_ready = 1'b0;
    matched   = '0;
    #1;
    checkOutput("idle_valid", int'(out_valid), 0);
    checkOutput("idle_last", int'(out_last), 0);
    checkOutput("idle_busy", int'(busy), 0);
    checkOutput("done_pulse", int'(done), 1);
    checkOutput("hit_done", int'(hit), int'(exp_hit));
    checkOutput("count_done", int'(match_count), exp_count);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [19:0] m;
    int          pick;
    reset     = 1'b1;
    load      = 1'b0;
    matched   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    checkOutput("rst_valid", int'(out_valid), 0);
    checkOutput("rst_last", int'(out_last), 0);
    checkOutput("rst_addr", int'(out_addr), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_hit", int'(hit), 0);
    checkOutput("rst_count", int'(match_count), 0);
    checkOutput("rst_done", int'(done), 0);

`ifdef TCAM_ENC_HIGH_FIRST_EN
    vecs.push_back('{20'h80011, 0, 3,  1'b1, 19});
    vecs.push_back('{20'h00006, 3, 2,  1'b1, 2});
    vecs.push_back('{20'h00000, 0, 0,  1'b0, -1});
    vecs.push_back('{20'h00001, 0, 1,  1'b1, 0});
    vecs.push_back('{20'h40000, 0, 1,  1'b1, 18});
    vecs.push_back('{20'hFFFFF, 1, 20, 1'b1, 19});
    vecs.push_back('{20'h80000, 2, 1,  1'b1, 19});
`else
    vecs.push_back('{20'h80011, 0, 3,  1'b1, 0});
    vecs.push_back('{20'h00006, 3, 2,  1'b1, 1});
    vecs.push_back('{20'h00000, 0, 0,  1'b0, -1});
    vecs.push_back('{20'h00001, 0, 1,  1'b1, 0});
    vecs.push_back('{20'h40000, 0, 1,  1'b1, 18});
    vecs.push_back('{20'hFFFFF, 1, 20, 1'b1, 0});
    vecs.push_back('{20'h80000, 2, 1,  1'b1, 19});
`endif
    for (int v = 0; v < vecs.size(); v++) begin
      applyStimulus(vecs[v].matched, vecs[v].stall, 1'b0, vecs[v].exp_first,
                    vecs[v].exp_count, vecs[v].exp_hit);
    end

    // Reset two handshakes into a four-entry drain: no done, all status cleared.
    load      = 1'b1;
    matched   = 20'h0000F;
    out_ready = 1'b0;
    #1;
    tick();
    load      = 1'b0;
    out_ready = 1'b1;
    #1;
`ifdef TCAM_ENC_HIGH_FIRST_EN
    checkOutput("rstmid_addr0", int'(out_addr), 3);
`else
    checkOutput("rstmid_addr0", int'(out_addr), 0);
`endif
    tick();
    #1;
`ifdef TCAM_ENC_HIGH_FIRST_EN
    checkOutput("rstmid_addr1", int'(out_addr), 2);
`else
    checkOutput("rstmid_addr1", int'(out_addr), 1);
`endif
    tick();
    out_ready = 1'b0;
    reset     = 1'b1;
    #1;
    tick();
    reset = 1'b0;
    #1;
    checkOutput("rstmid_valid", int'(out_valid), 0);
    checkOutput("rstmid_hit", int'(hit), 0);
    checkOutput("rstmid_count", int'(match_count), 0);
    checkOutput("rstmid_done", int'(done), 0);
    checkOutput("rstmid_addr", int'(out_addr), 0);
    tick();
    #1;
    checkOutput("rstmid_done2", int'(done), 0);
    checkOutput("rstmid_valid2", int'(out_valid), 0);

    for (int n = 0; n < 40; n++) begin
      pick = $urandom_range(0, 3);
      if (pick == 0)      m = '0;
      else if (pick == 1) m = 20'(1) << $urandom_range(0, 19);
      else                m = 20'($urandom & $urandom);
      applyStimulus(m, 0, 1'b1, -1, $countones(m), (m != '0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tcam_match_encoder.md
# tcam_match_encoder

Consumer-side companion to the ternary CAM array. It captures the per-entry `matched` vector produced by a search and returns the index of every matching entry, one per cycle, over a valid/ready stream. Entries are emitted lowest index first by default. It sits between the CAM and the lookup controller. It turns a wide one-hot/multi-hot hit vector into a sequence of addresses, plus a hit flag and a match count.

## Interface
Parameters:
- `MEMORY_SIZE`, default 20: number of CAM entries, which is the width of `matched`.
- `ADDR_WIDTH`, localparam, `$clog2(MEMORY_SIZE)`: index width.
- `CNT_WIDTH`, localparam, `$clog2(MEMORY_SIZE+1)`: count width.

Ports:
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `matched`, input, `MEMORY_SIZE`: search result from the CAM; bit i set means entry i hit.
- `load`, input, 1: capture `matched` this cycle. Honoured only in IDLE.
- `out_valid`, output, 1: `out_addr` holds a pending match index.
- `out_ready`, input, 1: consumer accepts `out_addr`.
- `out_addr`, output, `ADDR_WIDTH`: index of the current match.
- `out_last`, output, 1: the current index is the final pending match.
- `busy`, output, 1: the block is in EMIT state.
- `hit`, output, 1: at least one bit was set in the last captured vector.
- `match_count`, output, `CNT_WIDTH`: population count of the last captured vector.
- `done`, output, 1: one-cycle pulse when a capture has been fully drained.

## Operation
- Internal state:
  - `pending` register, `MEMORY_SIZE` bits.
  - Two-state FSM with states IDLE and EMIT.
- IDLE with `load`=1:
  - `pending` <= `matched`.
  - `hit` <= |`matched`.
  - `match_count` <= popcount(`matched`).
  - If `matched` is nonzero, go to EMIT. Otherwise stay in IDLE and assert `done` for one cycle.
- EMIT, combinational outputs from `pending`:
  - `out_valid`=1.
  - `out_addr` = index of the lowest set bit of `pending`.
  - `out_last` = 1 exactly when `pending` has one bit set.
- Handshake (`out_valid` & `out_ready`):
  - Clear the emitted bit in `pending`.
  - If `out_last` was set, go to IDLE and pulse `done` the following cycle.
- `out_addr` and `out_last` stay stable while `out_valid`=1 and `out_ready`=0.
- `load` in EMIT is ignored. The `matched` input is not sampled and the current drain is not disturbed.
- `hit` and `match_count` hold their values until the next accepted `load`. They do not decrement during draining.
- In IDLE, `out_valid`=0 and `out_last`=0. `out_addr` holds its last value, which is don't-care for the consumer.
- Bits of `matched` at or above `MEMORY_SIZE` do not exist. For non-power-of-2 sizes, `out_addr` never exceeds `MEMORY_SIZE-1`.

## Timing
- Reset (`reset`=1 at a rising edge) produces:
  - FSM in IDLE, `pending`=0.
  - `out_valid`=0, `out_last`=0, `out_addr`=0, `busy`=0.
  - `hit`=0, `match_count`=0, `done`=0.
- Reset in the middle of EMIT abandons the drain immediately. No `done` pulse is generated.
- Latency: `load` sampled at edge N gives `out_valid`=1 during cycle N+1.
- Throughput: with `out_ready` held high, one index per cycle. K matches drain in K cycles.
- `done` for a nonzero capture is high during the cycle after the final handshake. At that point the FSM is already in IDLE, so a `load` in that same cycle is accepted.
- `done` for a zero capture is high during cycle N+1 after `load` at edge N. `out_valid` never rises.
- Back-to-back operation: a `load` in the `done` cycle starts a new capture, and `out_valid` rises on the next cycle.
- `busy` equals `out_valid`.

## Configuration
- `TCAM_ENC_HIGH_FIRST_EN`:
  - Defined: entries are emitted highest index first. `out_addr` is the highest set bit of `pending`, and `out_last` is unchanged in meaning.
  - Undefined (default): entries are emitted lowest index first.
- `hit`, `match_count` and `done` behave identically in both builds.

## Test plan
- **Reset mid-drain:** load 20'h0000F, accept two indices, then assert `reset` one cycle.
  - Required: the next cycle shows `out_valid`=0, `hit`=0, `match_count`=0, and no `done` pulse.
- **Multi-hit drain:** `load` with `matched`=20'h80011 and `out_ready`=1.
  - Required: `out_addr` reads 0, 4, 19 on three consecutive cycles.
  - Required: `out_last`=1 only on 19, `match_count`=3, `hit`=1, and `done` the cycle after 19.
- **Backpressure:** `matched`=20'h00006, with `out_ready` low for 3 cycles and then high.
  - Required: `out_addr`=1 held stable for 3 cycles, then 1, then 2.
  - Required: a `load` asserted during the stall with 20'hFFFFF is ignored, so `match_count` stays 2.
- **Miss:** `load` with `matched`=0.
  - Required: `out_valid` stays 0, `done`=1 at N+1, `hit`=0, `match_count`=0.
- **Back-to-back captures:** drain 20'h00001, then assert `load` with 20'h40000 in the `done` cycle.
  - Required: `out_addr`=18 with `out_valid`=1 on the next cycle.
- **`TCAM_ENC_HIGH_FIRST_EN` build:** `matched`=20'h80011.
  - Required: order 19, 4, 0, with `out_last` on 0.
